// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues one-cycle load/store strobes, waits for mem_done
// with a 15-cycle timeout, retires to writeback. Optional MEM_ALIGN_CHECK_EN traps odd addresses.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_result,
  input  logic [15:0] write_data,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [15:0] read_data,
  output logic        stall,
  output logic        valid_out,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       is_load;
  logic [3:0] tmo_cnt;
  logic       mem_op;
  logic       one_op;
  logic       bad_req;

  assign mem_op = valid_in & (mem_read | mem_write);
  assign one_op = valid_in & (mem_read ^ mem_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_req = (valid_in & mem_read & mem_write) | (one_op & alu_result[0]);
`else
  assign bad_req = valid_in & mem_read & mem_write;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bad_req)     state_nxt = S_ERR;
        else if (one_op) state_nxt = S_REQ;
      end
      S_REQ:  state_nxt = mem_done ? S_DONE : S_WAIT;
      // The 15th consecutive WAIT cycle without mem_done sees tmo_cnt == 14.
      S_WAIT: begin
        if (mem_done)              state_nxt = S_DONE;
        else if (tmo_cnt == 4'd14) state_nxt = S_ERR;
      end
      S_DONE: state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      is_load   <= 1'b0;
      tmo_cnt   <= 4'd0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      read_data <= 16'h0000;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (one_op && !bad_req) begin
            mem_addr  <= alu_result;
            mem_wdata <= write_data;
            is_load   <= mem_read;
          end
        end
        S_REQ: begin
          tmo_cnt <= 4'd0;
          if (mem_done && is_load) read_data <= mem_rdata;
        end
        S_WAIT: begin
          if (mem_done) begin
            if (is_load) read_data <= mem_rdata;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_en = (state == S_REQ) &  is_load;
  assign mem_wr_en = (state == S_REQ) & ~is_load;
  assign err       = (state == S_ERR);
  assign valid_out = (state == S_DONE) |
                     ((state == S_IDLE) & valid_in & ~mem_read & ~mem_write);
  assign stall     = (state == S_REQ) | (state == S_WAIT) | (state == S_ERR) |
                     ((state == S_IDLE) & mem_op);

endmodule
